uart_rx_param: RTL and testbench

- Parametrised UART receiver for the Logic Sniffer host command path. It is the generalised successor of the fixed 8N1 115200-baud receive path.
- Converts the asynchronous `rx` line into data words with a valid/ready output handshake.
- Adds oversampled majority-vote sampling, configurable data width, parity and stop bits, framing/parity/overrun error flags, and break detection.
- Sits between the `rx` pin and the command decoder.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and baud divider helper for the UART receiver.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER,
        S_BRK
    } rx_state_t;

    // Rounded clock divider producing one oversample tick
    function automatic int unsigned calc_div(input longint unsigned clk_freq,
                                             input longint unsigned baud,
                                             input longint unsigned os);
        longint unsigned den;
        den = baud * os;
        return 32'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: DIV-clock divider plus tick index within the bit.
`timescale 1ns/1ps
module uart_baud_tick #(
    parameter int unsigned DIV        = 54,
    parameter int unsigned OVERSAMPLE = 16,
    localparam int unsigned IDX_W     = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    output logic             tick_c,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && !restart && (cnt == CNT_W'(DIV - 1));

    // Divider and tick index; both held at zero while disabled or restarting
    always_ff @(posedge clk) begin
        if (!rst_n || restart || !en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with error flags and break detection.
`timescale 1ns/1ps
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 bf_clock,
    input  logic                 extResetn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 break_det,
    output logic                 busy
);

    localparam int unsigned DIV   = calc_div(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE));
    localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] SMP0 = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] SMP1 = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] SMP2 = IDX_W'(OVERSAMPLE / 2 + 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_param: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
    end
    if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be 8 or 16");
    end

    rx_state_t            state;
    logic                 rx_m;
    logic                 rx_s;
    logic                 s0;
    logic                 s1;
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 fe_r;
    logic                 pe_r;
    logic                 brk_r;

    logic                 tick_c;
    logic [IDX_W-1:0]     idx;
    logic                 restart_c;
    logic                 decide_c;
    logic                 maj_c;
    logic                 stop_last_c;
    logic                 load_c;
    logic                 drop_c;

    assign restart_c   = (state == S_IDLE) && !rx_s;
    assign decide_c    = tick_c && (idx == SMP2);
    assign maj_c       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign stop_last_c = (STOP_BITS == 2) ? stop_cnt : 1'b1;
    assign load_c      = (state == S_DELIVER) && !brk_r && (!data_valid || data_ready);
    assign drop_c      = (state == S_DELIVER) && !brk_r && data_valid && !data_ready;

    uart_baud_tick #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk     (bf_clock),
        .rst_n   (extResetn),
        .en      (state != S_IDLE),
        .restart (restart_c),
        .tick_c  (tick_c),
        .idx     (idx)
    );

    // Two-flop synchroniser on the asynchronous line, idling high
    always_ff @(posedge bf_clock) begin
        if (!extResetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: sampling, shift register, parity/stop checks and busy flag
    always_ff @(posedge bf_clock) begin
        if (!extResetn) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            fe_r     <= 1'b0;
            pe_r     <= 1'b0;
            brk_r    <= 1'b0;
        end else begin
            if (tick_c && idx == SMP0) s0 <= rx_s;
            if (tick_c && idx == SMP1) s1 <= rx_s;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    fe_r     <= 1'b0;
                    pe_r     <= 1'b0;
                    brk_r    <= 1'b0;
                    par_bit  <= 1'b0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    if (decide_c) begin
                        if (maj_c) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (decide_c) begin
                        shreg <= {maj_c, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (decide_c) begin
                        par_bit <= maj_c;
                        pe_r    <= (PARITY == PAR_ODD) ? ~(^shreg ^ maj_c) : (^shreg ^ maj_c);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide_c) begin
                        if (!maj_c) fe_r <= 1'b1;
                        if (!stop_cnt && !maj_c && shreg == '0 && !par_bit) brk_r <= 1'b1;
                        if (stop_last_c) begin
                            state <= S_DELIVER;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                S_DELIVER: begin
                    if (brk_r) begin
                        state <= S_BRK;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_BRK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake, overrun and break pulse
    always_ff @(posedge bf_clock) begin
        if (!extResetn) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            break_det <= (state == S_DELIVER) && brk_r;
            if (load_c) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                frame_err  <= fe_r;
                parity_err <= pe_r;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: 8N1 default receiver (a) and a fast 8E2 receiver (b).
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BIT_A = 868;   // 8680 ns bits on the default 115200 receiver
    localparam int BIT_B = 104;   // 1 Mbaud, OVERSAMPLE 8 -> DIV 13

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       dv_a, fe_a, pe_a, ov_a, brk_a, busy_a;
    logic       dv_b, fe_b, pe_b, ov_b, brk_b, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc_b = 0;
    int vcount_a = 0, vcount_b = 0;
    int brk_cnt_a = 0, brk_cnt_b = 0;
    logic dv_a_q = 1'b0, dv_b_q = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_param u_dut_a (
        .bf_clock (clk), .extResetn (rst_n), .rx (rx_a),
        .data_out (dout_a), .data_valid (dv_a), .data_ready (rdy_a),
        .frame_err (fe_a), .parity_err (pe_a), .overrun (ov_a),
        .err_clr (clr_a), .break_det (brk_a), .busy (busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ (100000000), .BAUD (1000000), .OVERSAMPLE (8),
        .DATA_BITS (8), .PARITY (2), .STOP_BITS (2)
    ) u_dut_b (
        .bf_clock (clk), .extResetn (rst_n), .rx (rx_b),
        .data_out (dout_b), .data_valid (dv_b), .data_ready (rdy_b),
        .frame_err (fe_b), .parity_err (pe_b), .overrun (ov_b),
        .err_clr (clr_b), .break_det (brk_b), .busy (busy_b)
    );

    // Scoreboard: compare each accepted word against the expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv_a && rdy_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL sb_a unexpected word got=%h fe=%b pe=%b", dout_a, fe_a, pe_a);
                end else begin
                    e_a = q_a.pop_front();
                    if ({dout_a, fe_a, pe_a} !== {e_a.d, e_a.fe, e_a.pe}) begin
                        errors++;
                        $display("FAIL sb_a got=%h/%b/%b want=%h/%b/%b",
                                 dout_a, fe_a, pe_a, e_a.d, e_a.fe, e_a.pe);
                    end
                end
            end
            if (dv_b && rdy_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL sb_b unexpected word got=%h fe=%b pe=%b", dout_b, fe_b, pe_b);
                end else begin
                    e_b = q_b.pop_front();
                    if ({dout_b, fe_b, pe_b} !== {e_b.d, e_b.fe, e_b.pe}) begin
                        errors++;
                        $display("FAIL sb_b got=%h/%b/%b want=%h/%b/%b",
                                 dout_b, fe_b, pe_b, e_b.d, e_b.fe, e_b.pe);
                    end
                end
            end
            if (dv_a && !dv_a_q) vcount_a++;
            if (dv_b && !dv_b_q) begin
                vcount_b++;
                rise_cyc_b = cyc;
            end
            if (brk_a) brk_cnt_a++;
            if (brk_b) brk_cnt_b++;
        end
        dv_a_q = dv_a;
        dv_b_q = dv_b;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    function automatic logic even_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // One frame, LSB first; receiver b adds parity bit and a second stop bit
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                              input logic st0, input logic st1);
        int bc;
        bc = (sel == 0) ? BIT_A : BIT_B;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive(sel, 1'b0);
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clks(bc);
        end
        if (sel == 1) begin
            drive(sel, pbit);
            wait_clks(bc);
        end
        drive(sel, st0);
        wait_clks(bc);
        if (sel == 1) begin
            drive(sel, st1);
            wait_clks(bc);
        end
        drive(sel, 1'b1);
        wait_clks(bc);
    endtask

    task automatic pulse_ready_b(input int n);
        int tgt;
        @(posedge clk);
        #2;
        tgt = start_cyc + n - 1;
        for (int k = 0; k < 20 * BIT_B; k++) begin
            @(posedge clk);
            #1;
            if (cyc == tgt) begin
                rdy_b = 1'b1;
                @(posedge clk);
                #1;
                rdy_b = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(5);
        checks++;
        if ({dout_a, dv_a, fe_a, pe_a, ov_a, brk_a, busy_a} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a outputs got=%h want=0",
                     {dout_a, dv_a, fe_a, pe_a, ov_a, brk_a, busy_a});
        end
        checks++;
        if ({dout_b, dv_b, fe_b, pe_b, ov_b, brk_b, busy_b} !== 14'h0) begin
            errors++;
            $display("FAIL reset_b outputs got=%h want=0",
                     {dout_b, dv_b, fe_b, pe_b, ov_b, brk_b, busy_b});
        end
        rst_n = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_basic();
        int v0;
        rdy_a = 1'b1;
        v0 = vcount_a;
        q_a.push_back('{d: 8'h02, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'h02, 1'b0, 1'b1, 1'b1);
        checks++;
        if (vcount_a - v0 != 1) begin
            errors++;
            $display("FAIL basic_valid_pulses got=%0d want=1", vcount_a - v0);
        end
        checks++;
        if ({busy_a, dv_a, ov_a} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle busy/dv/ov got=%b want=000", {busy_a, dv_a, ov_a});
        end
    endtask

    task automatic test_parity();
        rdy_b = 1'b1;
        q_b.push_back('{d: 8'hA5, fe: 1'b0, pe: even_err(8'hA5, 1'b0)});
        send_frame(1, 8'hA5, 1'b0, 1'b1, 1'b1);
        q_b.push_back('{d: 8'hA5, fe: 1'b0, pe: even_err(8'hA5, 1'b1)});
        send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({busy_b, ov_b} !== 2'b00) begin
            errors++;
            $display("FAIL parity_idle busy/ov got=%b want=00", {busy_b, ov_b});
        end
    endtask

    task automatic test_framing();
        q_a.push_back('{d: 8'h55, fe: 1'b1, pe: 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL framing_a_busy got=%b want=0", busy_a);
        end
        q_b.push_back('{d: 8'h55, fe: 1'b1, pe: even_err(8'h55, 1'b0)});
        send_frame(1, 8'h55, 1'b0, 1'b1, 1'b0);
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL framing_b_busy got=%b want=0", busy_b);
        end
    endtask

    task automatic test_overrun();
        int n;
        rdy_b = 1'b0;
        q_b.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
        send_frame(1, 8'h11, ^8'h11, 1'b1, 1'b1);
        send_frame(1, 8'h22, ^8'h22, 1'b1, 1'b1);
        checks++;
        if ({dv_b, dout_b, ov_b} !== {1'b1, 8'h11, 1'b1}) begin
            errors++;
            $display("FAIL overrun_hold dv/dout/ov got=%b/%h/%b want=1/11/1", dv_b, dout_b, ov_b);
        end
        clr_b = 1'b1;
        wait_clks(1);
        clr_b = 1'b0;
        checks++;
        if (ov_b !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got=%b want=0", ov_b);
        end
        rdy_b = 1'b1;
        wait_clks(3);
        rdy_b = 1'b0;
        checks++;
        if (dv_b !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain dv got=%b want=0", dv_b);
        end
        // Same again, accepting the old word in the exact cycle the new one lands
        q_b.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
        send_frame(1, 8'h11, ^8'h11, 1'b1, 1'b1);
        n = rise_cyc_b - start_cyc;
        checks++;
        if (n <= 0 || n > 13 * BIT_B) begin
            errors++;
            $display("FAIL overrun_latency got=%0d want 1..%0d", n, 13 * BIT_B);
        end
        q_b.push_back('{d: 8'h22, fe: 1'b0, pe: 1'b0});
        fork
            send_frame(1, 8'h22, ^8'h22, 1'b1, 1'b1);
            pulse_ready_b(n);
        join
        checks++;
        if ({dv_b, dout_b, ov_b} !== {1'b1, 8'h22, 1'b0}) begin
            errors++;
            $display("FAIL overrun_simul dv/dout/ov got=%b/%h/%b want=1/22/0", dv_b, dout_b, ov_b);
        end
        rdy_b = 1'b1;
        wait_clks(3);
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vcount_a;
        rx_a = 1'b0;
        wait_clks(5);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_detect busy got=%b want=1", busy_a);
        end
        wait_clks(15);
        rx_a = 1'b1;
        wait_clks(BIT_A);
        checks++;
        if ({busy_a, dv_a} !== 2'b00 || vcount_a != v0) begin
            errors++;
            $display("FAIL glitch_reject busy/dv got=%b words=%0d want=00 words=0",
                     {busy_a, dv_a}, vcount_a - v0);
        end
    endtask

    task automatic test_break();
        int v0, b0;
        v0 = vcount_b;
        b0 = brk_cnt_b;
        rx_b = 1'b0;
        wait_clks(12 * BIT_B);
        checks++;
        if (busy_b !== 1'b1) begin
            errors++;
            $display("FAIL break_busy got=%b want=1", busy_b);
        end
        checks++;
        if (brk_cnt_b - b0 != 1) begin
            errors++;
            $display("FAIL break_pulses got=%0d want=1", brk_cnt_b - b0);
        end
        rx_b = 1'b1;
        wait_clks(10);
        checks++;
        if ({busy_b, dv_b} !== 2'b00 || vcount_b != v0) begin
            errors++;
            $display("FAIL break_release busy/dv got=%b words=%0d want=00 words=0",
                     {busy_b, dv_b}, vcount_b - v0);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = vcount_b;
        rx_b = 1'b0;
        wait_clks(3 * BIT_B);
        rst_n = 1'b0;
        rx_b = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        checks++;
        if ({busy_b, dv_b} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid busy/dv got=%b want=00", {busy_b, dv_b});
        end
        wait_clks(2 * BIT_B);
        q_b.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
        send_frame(1, 8'h3C, ^8'h3C, 1'b1, 1'b1);
        checks++;
        if (vcount_b - v0 != 1) begin
            errors++;
            $display("FAIL reset_mid_words got=%0d want=1", vcount_b - v0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid();
        wait_clks(5);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d/%0d want=0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
